// File: rtl/a2d_arbiter_if.sv
// a2d_arbiter_if: bundles the requester handshakes, the A2D converter strobes and the
// arbiter status outputs of one a2d_arbiter instance.
//   slave  : the arbiter itself (takes requests and A2D results, drives grants and results)
//   master : the requesters / A2D side that drive the requests and the converter strobes
// Signals:
//   req0/chnnl0, req1/chnnl1 : level requests and the channel each requester wants
//   cnv_cmplt/res            : conversion-complete strobe and 12-bit result
//   clr_err                  : clears the sticky timeout flag
//   strt_cnv/chnnl           : start pulse and channel address towards the A2D
//   res_out                  : result of the last finished conversion
//   done0/done1/err          : completion pulses, err marks an abandoned conversion
//   busy/timeout_flag        : not-idle status and sticky timeout indicator
interface a2d_arbiter_if;
  logic        req0;
  logic [2:0]  chnnl0;
  logic        req1;
  logic [2:0]  chnnl1;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        clr_err;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic [11:0] res_out;
  logic        done0;
  logic        done1;
  logic        err;
  logic        busy;
  logic        timeout_flag;

  modport slave (
    input  req0, chnnl0, req1, chnnl1, cnv_cmplt, res, clr_err,
    output strt_cnv, chnnl, res_out, done0, done1, err, busy, timeout_flag
  );

  modport master (
    output req0, chnnl0, req1, chnnl1, cnv_cmplt, res, clr_err,
    input  strt_cnv, chnnl, res_out, done0, done1, err, busy, timeout_flag
  );
endinterface

// File: rtl/a2d_arbiter.sv
// a2d_arbiter: shares one A2D converter between two level-sensitive requesters.
// Round-robin grant on a last-owner pointer, one-cycle start pulse, completion or timeout
// in WAIT, and a one-cycle done pulse to the owner in DONE.
// Ports:
//   clk   : rising-edge system clock
//   rst_n : asynchronous active-low reset
//   bus   : a2d_arbiter_if.slave (requests, A2D strobes, results and status)
module a2d_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 4095
) (
  input logic           clk,
  input logic           rst_n,
  a2d_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

  localparam logic [15:0] TimerLast = 16'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [2:0]  chnnl_q, chnnl_d;
  logic [11:0] res_q, res_d;
  logic        strt_q, strt_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        err_q, err_d;
  logic        tflag_q, tflag_d;
  logic        grant;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    owner_d = owner_q;
    last_d  = last_q;
    chnnl_d = chnnl_q;
    res_d   = res_q;
    strt_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err_d   = 1'b0;
    // Clear first so that a timeout set below in the same cycle takes priority.
    tflag_d = tflag_q & ~bus.clr_err;
    // Both requesting: the one that did not own the converter last time wins.
    grant   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

    case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          owner_d = grant;
          chnnl_d = grant ? bus.chnnl1 : bus.chnnl0;
          strt_d  = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        if (bus.cnv_cmplt) begin
          res_d   = bus.res;
          done0_d = ~owner_q;
          done1_d = owner_q;
          state_d = StDone;
        end else if (timer_q == TimerLast) begin
          res_d   = 12'hFFF;
          tflag_d = 1'b1;
          err_d   = 1'b1;
          done0_d = ~owner_q;
          done1_d = owner_q;
          state_d = StDone;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StDone: begin
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      chnnl_q <= '0;
      res_q   <= '0;
      strt_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
      tflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      chnnl_q <= chnnl_d;
      res_q   <= res_d;
      strt_q  <= strt_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err_q   <= err_d;
      tflag_q <= tflag_d;
    end
  end

  assign bus.strt_cnv     = strt_q;
  assign bus.chnnl        = chnnl_q;
  assign bus.res_out      = res_q;
  assign bus.done0        = done0_q;
  assign bus.done1        = done1_q;
  assign bus.err          = err_q;
  assign bus.busy         = (state_q != StIdle);
  assign bus.timeout_flag = tflag_q;

endmodule

// File: tb/tb_a2d_arbiter.sv
// tb_a2d_arbiter: two arbiter instances (short timeout 16, default timeout 4095) driven by
// table vectors, hand sequences and random transactions, checked against a
// transaction-level model (round-robin pointer, sticky flag, last result).
module tb_a2d_arbiter;

  localparam int ToShort = 16;
  localparam int ToLong  = 4095;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        req0 = 1'b0;
  logic [2:0]  chnnl0 = '0;
  logic        req1 = 1'b0;
  logic [2:0]  chnnl1 = '0;
  logic        cnv_cmplt = 1'b0;
  logic [11:0] res = '0;
  logic        clr_err = 1'b0;

  always #10 clk = ~clk;

  a2d_arbiter_if bs ();
  a2d_arbiter_if bl ();

  // The unselected instance sees quiet inputs so its state stays predictable.
  assign bs.req0      = sel ? 1'b0 : req0;
  assign bs.chnnl0    = sel ? 3'd0 : chnnl0;
  assign bs.req1      = sel ? 1'b0 : req1;
  assign bs.chnnl1    = sel ? 3'd0 : chnnl1;
  assign bs.cnv_cmplt = sel ? 1'b0 : cnv_cmplt;
  assign bs.res       = sel ? 12'd0 : res;
  assign bs.clr_err   = sel ? 1'b0 : clr_err;
  assign bl.req0      = sel ? req0 : 1'b0;
  assign bl.chnnl0    = sel ? chnnl0 : 3'd0;
  assign bl.req1      = sel ? req1 : 1'b0;
  assign bl.chnnl1    = sel ? chnnl1 : 3'd0;
  assign bl.cnv_cmplt = sel ? cnv_cmplt : 1'b0;
  assign bl.res       = sel ? res : 12'd0;
  assign bl.clr_err   = sel ? clr_err : 1'b0;

  a2d_arbiter #(.TIMEOUT_CYC(ToShort)) u_short (.clk(clk), .rst_n(rst_n), .bus(bs));
  a2d_arbiter #(.TIMEOUT_CYC(ToLong))  u_long  (.clk(clk), .rst_n(rst_n), .bus(bl));

  typedef struct packed {
    logic        strt;
    logic [2:0]  ch;
    logic [11:0] ro;
    logic        d0;
    logic        d1;
    logic        er;
    logic        bz;
    logic        tf;
  } outs_t;

  outs_t os, ol;
  assign os = {bs.strt_cnv, bs.chnnl, bs.res_out, bs.done0, bs.done1, bs.err, bs.busy,
               bs.timeout_flag};
  assign ol = {bl.strt_cnv, bl.chnnl, bl.res_out, bl.done0, bl.done1, bl.err, bl.busy,
               bl.timeout_flag};

  function automatic outs_t outs(input bit lng);
    return lng ? ol : os;
  endfunction

  int    n_tests = 0;
  int    n_fail = 0;
  string tag = "";

  // Transaction-level model state, index 0 = short instance, 1 = long instance.
  int          last_m [2];
  bit          tflag_m [2];
  logic [11:0] res_m [2];

  function automatic int pick(input bit r0, input bit r1, input int last);
    if (r0 && r1) return 1 - last;
    return r1 ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, expected %0h", tag, nm, act, exp);
    end
  endtask

  task automatic chk_reset(input bit lng);
    outs_t o;
    o = outs(lng);
    chk("rst_strt", 32'(o.strt), 0);
    chk("rst_chnnl", 32'(o.ch), 0);
    chk("rst_res_out", 32'(o.ro), 0);
    chk("rst_done0", 32'(o.d0), 0);
    chk("rst_done1", 32'(o.d1), 0);
    chk("rst_err", 32'(o.er), 0);
    chk("rst_busy", 32'(o.bz), 0);
    chk("rst_tflag", 32'(o.tf), 0);
  endtask

  // One arbitrated conversion. d = cycles after the strt_cnv cycle at which cnv_cmplt pulses
  // (negative = never). Returns at the negedge inside the DONE cycle.
  task automatic txn(input bit lng, input bit r0, input logic [2:0] c0, input bit r1,
                     input logic [2:0] c1, input int d, input logic [11:0] rv, input bit keep,
                     input bit drop, input int eo, input logic [2:0] ech,
                     input logic [11:0] eres, input bit eerr);
    outs_t o;
    int    to;
    int    off;
    int    n;
    to  = lng ? ToLong : ToShort;
    off = (d >= 1 && d <= to) ? d + 1 : to + 1;
    sel = lng;
    cnv_cmplt = 1'b0;
    @(negedge clk);
    o = outs(lng);
    n = 0;
    while (o.bz && n < 40) begin
      @(negedge clk);
      o = outs(lng);
      n++;
    end
    chk("idle_reached", 32'(o.bz), 0);
    chk("idle_strt", 32'(o.strt), 0);
    chk("idle_done", 32'({o.d0, o.d1, o.er}), 0);
    chk("res_out_hold", 32'(o.ro), 32'(res_m[lng]));
    req0 = r0;
    chnnl0 = c0;
    req1 = r1;
    chnnl1 = c1;
    res = rv;
    @(negedge clk);
    o = outs(lng);
    chk("start_pulse", 32'(o.strt), 1);
    chk("start_chnnl", 32'(o.ch), 32'(ech));
    chk("start_busy", 32'(o.bz), 1);
    if (drop) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    cnv_cmplt = (d == 0);
    for (int c = 1; c <= off; c++) begin
      @(negedge clk);
      o = outs(lng);
      if (c == off) begin
        last_m[lng]  = eo;
        res_m[lng]   = eres;
        tflag_m[lng] = tflag_m[lng] | eerr;
        chk("done0", 32'(o.d0), 32'(eo == 0));
        chk("done1", 32'(o.d1), 32'(eo == 1));
        chk("done_err", 32'(o.er), 32'(eerr));
        chk("done_res_out", 32'(o.ro), 32'(eres));
        chk("done_chnnl", 32'(o.ch), 32'(ech));
        chk("done_tflag", 32'(o.tf), 32'(tflag_m[lng]));
        chk("done_busy_strt", 32'({o.bz, o.strt}), 2);
      end else begin
        chk("wait_strt", 32'(o.strt), 0);
        chk("wait_done", 32'({o.d0, o.d1, o.er}), 0);
        chk("wait_chnnl", 32'(o.ch), 32'(ech));
        chk("wait_busy", 32'(o.bz), 1);
      end
      cnv_cmplt = (d == c);
    end
    if (!keep) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
  endtask

  typedef struct {
    bit          lng;
    bit          r0;
    logic [2:0]  c0;
    bit          r1;
    logic [2:0]  c1;
    int          d;
    logic [11:0] rv;
    bit          keep;
    bit          drop;
    int          eo;
    logic [2:0]  ech;
    logic [11:0] eres;
    bit          eerr;
  } vec_t;

  vec_t tbl [9];

  initial begin
    outs_t       o;
    logic [1:0]  v;
    logic [2:0]  c0r, c1r;
    logic [11:0] rvr;
    int          dr;
    int          eo;
    bit          kp, dp, eerr;

    last_m  = '{1, 1};
    tflag_m = '{1'b0, 1'b0};
    res_m   = '{12'h000, 12'h000};

    tbl[0] = '{1'b1, 1'b1, 3'd4, 1'b0, 3'd0, 20, 12'hA5C, 1'b0, 1'b0, 0, 3'd4, 12'hA5C, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 3'd1, 1'b1, 3'd7, 3, 12'h123, 1'b1, 1'b0, 0, 3'd1, 12'h123, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 3'd0, 1'b1, 3'd7, 5, 12'h456, 1'b0, 1'b0, 1, 3'd7, 12'h456, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 3'd0, 1'b1, 3'd2, -1, 12'h000, 1'b0, 1'b0, 1, 3'd2, 12'hFFF, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 3'd5, 1'b1, 3'd6, 16, 12'h3C3, 1'b0, 1'b0, 0, 3'd5, 12'h3C3, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 3'd6, 1'b1, 3'd3, 1, 12'h7E1, 1'b0, 1'b0, 1, 3'd3, 12'h7E1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 3'd0, 1'b1, 3'd0, 0, 12'h111, 1'b0, 1'b1, 1, 3'd0, 12'hFFF, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 3'd7, 1'b0, 3'd0, 17, 12'h222, 1'b0, 1'b0, 0, 3'd7, 12'hFFF, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 3'd3, 1'b1, 3'd4, 7, 12'h0F0, 1'b0, 1'b1, 1, 3'd4, 12'h0F0, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tag = "reset_short";
    chk_reset(1'b0);
    tag = "reset_long";
    chk_reset(1'b1);

    for (int i = 0; i < 9; i++) begin
      tag = $sformatf("vec%0d", i);
      txn(tbl[i].lng, tbl[i].r0, tbl[i].c0, tbl[i].r1, tbl[i].c1, tbl[i].d, tbl[i].rv,
          tbl[i].keep, tbl[i].drop, tbl[i].eo, tbl[i].ech, tbl[i].eres, tbl[i].eerr);
    end

    // Sticky flag clear, then clear held across a new timeout: the set must win.
    tag = "clr";
    sel = 1'b0;
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    o = outs(1'b0);
    chk("tflag_cleared", 32'(o.tf), 0);
    tflag_m[0] = 1'b0;
    clr_err = 1'b1;
    tag = "clr_vs_set";
    txn(1'b0, 1'b1, 3'd1, 1'b0, 3'd0, -1, 12'h000, 1'b0, 1'b0, 0, 3'd1, 12'hFFF, 1'b1);
    @(negedge clk);
    o = outs(1'b0);
    chk("tflag_cleared_after", 32'(o.tf), 0);
    tflag_m[0] = 1'b0;
    clr_err = 1'b0;

    // Reset five cycles into WAIT, then a stray cnv_cmplt after release.
    tag = "rst_mid_wait";
    sel = 1'b0;
    @(negedge clk);
    req0 = 1'b1;
    chnnl0 = 3'd6;
    @(negedge clk);
    o = outs(1'b0);
    chk("start_pulse", 32'(o.strt), 1);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset(1'b0);
    req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cnv_cmplt = 1'b1;
    res = 12'hBAD;
    @(negedge clk);
    cnv_cmplt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_reset(1'b0);
      @(negedge clk);
    end
    last_m  = '{1, 1};
    tflag_m = '{1'b0, 1'b0};
    res_m   = '{12'h000, 12'h000};

    // Both requesters held for four conversions: grants alternate from requester 0.
    for (int i = 0; i < 4; i++) begin
      tag = $sformatf("alt%0d", i);
      txn(1'b0, 1'b1, 3'd2, 1'b1, 3'd5, 2, 12'h100 + 12'(i), (i < 3), 1'b0, i % 2,
          (i % 2 == 1) ? 3'd5 : 3'd2, 12'h100 + 12'(i), 1'b0);
    end

    for (int t = 0; t < 40; t++) begin
      tag = $sformatf("rnd%0d", t);
      v    = 2'($urandom_range(1, 3));
      c0r  = 3'($urandom);
      c1r  = 3'($urandom);
      dr   = int'($urandom_range(0, 18));
      rvr  = 12'($urandom);
      kp   = 1'($urandom);
      dp   = 1'($urandom);
      eo   = pick(v[0], v[1], last_m[0]);
      eerr = !(dr >= 1 && dr <= ToShort);
      txn(1'b0, v[0], c0r, v[1], c1r, dr, rvr, kp, dp, eo, (eo == 1) ? c1r : c0r,
          eerr ? 12'hFFF : rvr, eerr);
    end

    req0 = 1'b0;
    req1 = 1'b0;
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/a2d_arbiter.md
A2D_ARBITER -- requirements
Module: a2d_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 4095, giving the maximum WAIT-state cycles before a conversion is abandoned (legal range 2..65535).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports listed in REQ-003 and REQ-004.
REQ-003 clk  input  1  50MHz system clock; all flops SHALL be rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0  input  1  requester 0 (IR/PI math sequencer), level; held until done0.
REQ-006 chnnl0  input  3  A2D channel requested by requester 0; stable while req0 is high.
REQ-007 req1  input  1  requester 1 (battery/aux monitor), level; held until done1.
REQ-008 chnnl1  input  3  A2D channel requested by requester 1; stable while req1 is high.
REQ-009 cnv_cmplt  input  1  A2D conversion-complete strobe.
REQ-010 res  input  12  A2D result; valid when cnv_cmplt=1.
REQ-011 clr_err  input  1  synchronous clear of timeout_flag.
REQ-012 strt_cnv  output  1  one-cycle A2D start pulse, registered.
REQ-013 chnnl  output  3  registered A2D channel address of the granted requester.
REQ-014 res_out  output  12  registered result of the last finished conversion.
REQ-015 done0 / done1  output  1 each  one-cycle completion pulse to the owning requester.
REQ-016 err  output  1  one-cycle pulse, coincident with doneX, set when the conversion timed out.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 timeout_flag  output  1  sticky timeout indicator.

Function
REQ-019 The FSM SHALL have four states: IDLE, START, WAIT and DONE.
REQ-020 IDLE: when req0 or req1 is high at a clock edge, the block SHALL select an owner, register owner and its chnnlX into chnnl, and go to START; otherwise it SHALL stay in IDLE.
REQ-021 Arbitration SHALL be round-robin on a last-owner pointer: when both requests are high, the requester that is not last-owner wins; when only one is high, it wins.
REQ-022 The last-owner pointer SHALL reset to 1, so that requester 0 wins the first simultaneous request.
REQ-023 START: strt_cnv SHALL be 1 for exactly this one cycle, the 16-bit timer SHALL clear, and the next state SHALL be WAIT.
REQ-024 Latency: a request sampled at edge k SHALL produce strt_cnv=1 in cycle k+1.
REQ-025 cnv_cmplt SHALL be ignored in IDLE, START and DONE.
REQ-026 WAIT: when cnv_cmplt=1, res SHALL load into res_out, with next state DONE and err=0.
REQ-027 WAIT: otherwise, when timer==TIMEOUT_CYC-1, res_out SHALL load 12'hFFF, timeout_flag SHALL set, err SHALL pulse in DONE, and next state SHALL be DONE.
REQ-028 WAIT: otherwise, the timer SHALL increment.
REQ-029 If cnv_cmplt and the timeout coincide, cnv_cmplt SHALL win.
REQ-030 DONE: doneX for the owner SHALL be 1 for one cycle, res_out SHALL already hold the new value, the last-owner pointer SHALL update to the owner, and the next state SHALL be IDLE.
REQ-031 Minimum spacing between strt_cnv pulses SHALL be 4 cycles; after DONE, the block SHALL re-arbitrate in IDLE.
REQ-032 chnnl SHALL stay constant from START through DONE.
REQ-033 res_out SHALL hold its value until the next conversion finishes.
REQ-034 A request dropped mid-transaction SHALL NOT abort the transaction; doneX still pulses.
REQ-035 timeout_flag SHALL clear on clr_err=1; if clr_err and a new timeout coincide, the set SHALL win.

Reset
REQ-036 On rst_n=0 at any time, including mid-WAIT, the block SHALL go to IDLE with strt_cnv=0, chnnl=3'b000, res_out=12'h000, done0=done1=0, err=0, busy=0, timeout_flag=0, timer=0 and last-owner=1.
REQ-037 A cnv_cmplt arriving after reset SHALL be ignored.

Verification
REQ-038 req0=1, chnnl0=3'b100; cnv_cmplt with res=12'hA5C 20 cycles after strt_cnv -> strt_cnv pulse one cycle after req0 sampled, chnnl=3'b100, then next cycle done0=1 and res_out=12'hA5C, err=0.
REQ-039 After reset, req0=req1=1 in the same cycle (chnnl0=3'b001, chnnl1=3'b111) -> first strt_cnv with chnnl=3'b001 and done0, then second strt_cnv with chnnl=3'b111 and done1, with no done overlap.
REQ-040 req0 and req1 held high for four conversions -> grants alternate 0,1,0,1.
REQ-041 TIMEOUT_CYC=16, req1=1, no cnv_cmplt -> done1 and err pulse 16 cycles into WAIT, res_out=12'hFFF, timeout_flag=1; clr_err=1 -> timeout_flag=0.
REQ-042 rst_n asserted 5 cycles into WAIT, then cnv_cmplt pulsed after release -> all outputs at reset values, no doneX, busy=0.
REQ-043 cnv_cmplt and timeout in the same cycle -> res_out=res, err=0, timeout_flag unchanged.
